rans_enc_multi: RTL and testbench
=================================

// Module: rans_enc_multi
// PURPOSE
//  Interleaved N-channel byte-wise rANS encoder; successor to the single-state encoder.
//  - Accepts symbols with a loadable freq/cum table.
//  - Distributes symbols round-robin over NUM_CHANNELS independent states.
//  - Emits renormalisation words through a valid/ready stream.
//  - On flush, emits the final states so the decoder can start.
//  Sits between the symbol source (DMA/AXIS adapter) and the output packer.
// PARAMETERS
//  RESOLUTION    10  probability bits, M = 2^RESOLUTION
//  SYMBOL_WIDTH  8   symbol width and output word width (renorm shift amount)
//  NUM_CHANNELS  2   interleaved states, >= 1
//  STATE_WIDTH   32  state width
//  Legality: STATE_WIDTH % SYMBOL_WIDTH == 0; RESOLUTION <= STATE_WIDTH-SYMBOL_WIDTH.
//  Define L = 2^(STATE_WIDTH-SYMBOL_WIDTH).
// PORTS
//  clk_i        in   1                      single clock, rising edge
//  rst_i        in   1                      asynchronous, active-high reset
//  freq_wr_i    in   1                      write freq_i/cum_freq_i into table[symb_i]
//  freq_i       in   RESOLUTION             symbol frequency (0 illegal)
//  cum_freq_i   in   RESOLUTION             cumulative frequency
//  symb_i       in   SYMBOL_WIDTH           symbol to encode / table write address
//  en_i         in   1                      symbol valid
//  ready_o      out  1                      symbol accept; transfer = en_i & ready_o & !freq_wr_i
//  flush_i      in   1                      request final-state emission (sampled in IDLE)
//  valid_o      out  1                      output word valid
//  enc_o        out  SYMBOL_WIDTH           output word
//  chan_o       out  $clog2(NUM_CHANNELS)+1 channel that produced enc_o
//  out_ready_i  in   1                      downstream accept
//  done_o       out  1                      1-cycle pulse after the last flush word is accepted
//  err_o        out  1                      sticky; set when a symbol with freq==0 is received
// BEHAVIOUR
//  Reset (async), and the same state after any mid-operation reset:
//  - ready_o=0, valid_o=0, enc_o=0, chan_o=0, done_o=0, err_o=0.
//  - All states = L; channel pointer = 0; FSM in IDLE.
//  - Freq table is not reset. It is retained but undefined until written.
//  - ready_o rises on the first clk after rst_i falls.
//  FSM (one-hot or enum, from rans_pkg): IDLE -> LOOKUP -> RENORM -> DIVIDE -> UPDATE -> IDLE.
//  Flush path: IDLE -> FLUSH -> IDLE.
//  IDLE:
//  - ready_o=1.
//  - freq_wr_i has priority: table written, en_i and flush_i ignored that cycle.
//  - flush_i has priority over en_i.
//  LOOKUP (1 cycle, synchronous table read):
//  - freq==0 sets err_o, drops the symbol (pointer not advanced) and returns to IDLE.
//  RENORM:
//  - x_max = freq << (STATE_WIDTH-RESOLUTION), computed in STATE_WIDTH+1 bits.
//  - While x >= x_max: present enc_o = x[SYMBOL_WIDTH-1:0], chan_o = ptr, valid_o=1.
//  - On out_ready_i, x >>= SYMBOL_WIDTH; one word per accepted cycle.
//  - Continue when x < x_max.
//  DIVIDE: start rans_divider(x, freq) and wait for its done; STATE_WIDTH cycles.
//  UPDATE:
//  - x = (q << RESOLUTION) + r + cum, truncated to STATE_WIDTH.
//  - Write back to state[ptr]; ptr = (ptr == NUM_CHANNELS-1) ? 0 : ptr+1; go to IDLE.
//  Latency: ready_o drops on the edge that accepts a symbol. It rises again STATE_WIDTH+3+k cycles later.
//  - k = number of renorm words, with no backpressure.
//  - Each stall cycle adds one.
//  FLUSH:
//  - Emit states ch0..chN-1, each LSB word first, STATE_WIDTH/SYMBOL_WIDTH words per channel.
//  - chan_o = emitting channel.
//  - After the last word is accepted: done_o pulse, all states = L, ptr = 0, then IDLE.
//  - Flush with no symbols encoded emits the L values.
//  Output stream rule: while valid_o & !out_ready_i, enc_o and chan_o are held stable and valid_o stays 1.
// STRUCTURE
//  rans_pkg holds:
//  - fsm_state_t enum.
//  - function l_value(STATE_WIDTH,SYMBOL_WIDTH).
//  - function x_max(freq) width helper.
//  - Table entry struct {freq, cum}.
//  Sub-module rans_divider: iterative restoring divider, STATE_WIDTH/RESOLUTION widths.
//  - Ports: start, dividend, divisor, done, quotient, remainder.
//  Freq table: 2^SYMBOL_WIDTH x 2*RESOLUTION synchronous RAM, inferred in-module.
//  States: NUM_CHANNELS x STATE_WIDTH register array.
// TESTING (default params; table[0x41]={512,0}, table[0x42]={1,5})
//  1. Reset mid-DIVIDE -> all outputs 0.
//     Then flush -> words 00 00 00 01 (chan 0), 00 00 00 01 (chan 1), then done_o.
//  2. Encode 0x41 -> no output words; ready_o back after 35 cycles.
//     Flush -> 00 00 00 02 (ch0), 00 00 00 01 (ch1).
//  3. Encode 0x42 -> one word 0x00 on ch0; state 0x0400_0005.
//     Flush first words -> 05 00 00 04.
//  4. Encode 0x41,0x41 -> one symbol on each of ch0/ch1, both states 0x0200_0000.
//     Round-robin verified through chan_o in flush.
//  5. Hold out_ready_i=0 for 10 cycles during test-3 renorm -> enc_o/valid_o stable.
//     ready_o is delayed by 10 cycles.
//  6. Encode a symbol with freq=0 -> err_o=1 (sticky), ptr unchanged.
//     freq_wr_i with en_i in the same cycle -> write only, symbol not accepted.

Source files
------------

// File: rtl/rans_pkg.sv
// Shared types and helpers for the interleaved rANS encoder.
// Default widths live here so the table entry type matches the top.
package rans_pkg;

    localparam int RANS_RES  = 10;
    localparam int RANS_SYMW = 8;
    localparam int RANS_CH   = 2;
    localparam int RANS_SW   = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_RENORM,
        S_DIVIDE,
        S_UPDATE,
        S_FLUSH
    } fsm_state_t;

    typedef struct packed {
        logic [RANS_RES-1:0] freq;
        logic [RANS_RES-1:0] cum;
    } tbl_ent_t;

    function automatic logic [63:0] l_value(input int sw, input int symw);
        return 64'd1 << (sw - symw);
    endfunction

    // Wide enough that freq << shift can never overflow the compare.
    function automatic logic [63:0] x_max(input logic [63:0] freq,
                                          input int shift);
        return freq << shift;
    endfunction

endpackage

// File: rtl/rans_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// done_o is high during the last step; results are final the cycle after.
module rans_divider #(
    parameter int STATE_WIDTH = 32,
    parameter int RESOLUTION  = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [STATE_WIDTH-1:0] dividend_i,
    input  logic [RESOLUTION-1:0]  divisor_i,
    output logic                   done_o,
    output logic [STATE_WIDTH-1:0] quotient_o,
    output logic [RESOLUTION-1:0]  remainder_o
);

    localparam int CNW = $clog2(STATE_WIDTH + 1);

    logic [STATE_WIDTH-1:0] quo_q, quo_d;
    logic [RESOLUTION-1:0]  rem_q, rem_d;
    logic [RESOLUTION-1:0]  dvs_q, dvs_d;
    logic [CNW-1:0]         cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic [RESOLUTION:0]    trial;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        trial  = {rem_q, quo_q[STATE_WIDTH-1]};
        if (start_i) begin
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
            cnt_d  = CNW'(STATE_WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial >= {1'b0, dvs_q}) begin
                rem_d = RESOLUTION'(trial - {1'b0, dvs_q});
                quo_d = {quo_q[STATE_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = trial[RESOLUTION-1:0];
                quo_d = {quo_q[STATE_WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNW'(1);
            if (cnt_q == CNW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done_o      = busy_q && (cnt_q == CNW'(1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/rans_enc_multi.sv
// Interleaved N-channel byte-wise rANS encoder with loadable freq table.
// Symbols go round-robin over the channel states; flush drains them all.
module rans_enc_multi
    import rans_pkg::*;
#(
    parameter int RESOLUTION   = RANS_RES,
    parameter int SYMBOL_WIDTH = RANS_SYMW,
    parameter int NUM_CHANNELS = RANS_CH,
    parameter int STATE_WIDTH  = RANS_SW
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            freq_wr_i,
    input  logic [RESOLUTION-1:0]           freq_i,
    input  logic [RESOLUTION-1:0]           cum_freq_i,
    input  logic [SYMBOL_WIDTH-1:0]         symb_i,
    input  logic                            en_i,
    output logic                            ready_o,
    input  logic                            flush_i,
    output logic                            valid_o,
    output logic [SYMBOL_WIDTH-1:0]         enc_o,
    output logic [$clog2(NUM_CHANNELS):0]   chan_o,
    input  logic                            out_ready_i,
    output logic                            done_o,
    output logic                            err_o
);

    localparam int CW    = $clog2(NUM_CHANNELS) + 1;
    localparam int PW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int NSLOT = 2 ** PW;
    localparam int NW    = STATE_WIDTH / SYMBOL_WIDTH;
    localparam int WBW   = (NW > 1) ? $clog2(NW) : 1;
    localparam int XSH   = STATE_WIDTH - RESOLUTION;
    localparam logic [STATE_WIDTH-1:0] L_VAL =
        STATE_WIDTH'(l_value(STATE_WIDTH, SYMBOL_WIDTH));

    fsm_state_t             state_q, state_d;
    logic [STATE_WIDTH-1:0] st_q [NSLOT];
    logic [STATE_WIDTH-1:0] st_d [NSLOT];
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [PW-1:0]          fch_q, fch_d;
    logic [WBW-1:0]         widx_q, widx_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   run_q;

    tbl_ent_t tbl_mem [2**SYMBOL_WIDTH];
    tbl_ent_t ent_q;

    logic                   idle_rdy;
    logic                   sym_go;
    logic                   flush_go;
    logic [STATE_WIDTH-1:0] x_cur;
    logic [63:0]            xmax_w;
    logic                   need_renorm;
    logic                   div_start;
    logic                   div_done;
    logic [STATE_WIDTH-1:0] div_q;
    logic [RESOLUTION-1:0]  div_r;
    logic [STATE_WIDTH-1:0] upd;
    logic                   last_word;
    logic                   last_chan;

    assign idle_rdy  = (state_q == S_IDLE) && run_q;
    assign flush_go  = idle_rdy && flush_i && !freq_wr_i;
    assign sym_go    = idle_rdy && en_i && !flush_i && !freq_wr_i;
    assign x_cur     = st_q[ptr_q];
    assign xmax_w    = x_max(64'(ent_q.freq), XSH);
    assign need_renorm = 64'(x_cur) >= xmax_w;
    assign div_start = (state_q == S_RENORM) && !need_renorm;
    assign upd       = (div_q << RESOLUTION) + STATE_WIDTH'(div_r)
                     + STATE_WIDTH'(ent_q.cum);
    assign last_word = widx_q == WBW'(NW - 1);
    assign last_chan = fch_q == PW'(NUM_CHANNELS - 1);

    // Table is deliberately not reset; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (freq_wr_i) begin
            tbl_mem[symb_i] <= '{freq: freq_i, cum: cum_freq_i};
        end
        if (sym_go) begin
            ent_q <= tbl_mem[symb_i];
        end
    end

    rans_divider #(
        .STATE_WIDTH(STATE_WIDTH),
        .RESOLUTION (RESOLUTION)
    ) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (div_start),
        .dividend_i (x_cur),
        .divisor_i  (ent_q.freq),
        .done_o     (div_done),
        .quotient_o (div_q),
        .remainder_o(div_r)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush_go) begin
                    state_d = S_FLUSH;
                end else if (sym_go) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = (ent_q.freq == '0) ? S_IDLE : S_RENORM;
            end
            S_RENORM: begin
                if (!need_renorm) begin
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (div_done) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: state_d = S_IDLE;
            S_FLUSH: begin
                if (out_ready_i && last_word && last_chan) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o = idle_rdy;
        valid_o = 1'b0;
        enc_o   = '0;
        chan_o  = '0;
        done_o  = done_q;
        err_o   = err_q;
        if (state_q == S_RENORM && need_renorm) begin
            valid_o = 1'b1;
            enc_o   = SYMBOL_WIDTH'(x_cur);
            chan_o  = CW'(ptr_q);
        end else if (state_q == S_FLUSH) begin
            valid_o = 1'b1;
            enc_o   = SYMBOL_WIDTH'(st_q[fch_q]
                      >> (SYMBOL_WIDTH * int'(widx_q)));
            chan_o  = CW'(fch_q);
        end
    end

    always_comb begin
        st_d   = st_q;
        ptr_d  = ptr_q;
        fch_d  = fch_q;
        widx_d = widx_q;
        err_d  = err_q;
        done_d = 1'b0;
        unique case (state_q)
            S_LOOKUP: begin
                if (ent_q.freq == '0) begin
                    err_d = 1'b1;
                end
            end
            S_RENORM: begin
                if (need_renorm && out_ready_i) begin
                    st_d[ptr_q] = x_cur >> SYMBOL_WIDTH;
                end
            end
            S_UPDATE: begin
                st_d[ptr_q] = upd;
                ptr_d = (ptr_q == PW'(NUM_CHANNELS - 1)) ? '0
                                                         : ptr_q + PW'(1);
            end
            S_FLUSH: begin
                if (out_ready_i) begin
                    if (!last_word) begin
                        widx_d = widx_q + WBW'(1);
                    end else if (!last_chan) begin
                        widx_d = '0;
                        fch_d  = fch_q + PW'(1);
                    end else begin
                        widx_d = '0;
                        fch_d  = '0;
                        ptr_d  = '0;
                        done_d = 1'b1;
                        for (int i = 0; i < NSLOT; i++) begin
                            st_d[i] = L_VAL;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NSLOT; i++) begin
                st_q[i] <= L_VAL;
            end
            ptr_q  <= '0;
            fch_q  <= '0;
            widx_q <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            ptr_q  <= ptr_d;
            fch_q  <= fch_d;
            widx_q <= widx_d;
            err_q  <= err_d;
            done_q <= done_d;
            run_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rans_enc_multi.sv
// Directed bench for rans_enc_multi with hand-computed rANS results.
// Table: 0x41={512,0}, 0x42={1,5}, 0x43={0,0}, 0x44={256,3}.
module tb_rans_enc_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       freq_wr = 1'b0;
    logic [9:0] freq = '0;
    logic [9:0] cum = '0;
    logic [7:0] symb = '0;
    logic       en = 1'b0;
    logic       ready_o;
    logic       flush = 1'b0;
    logic       valid_o;
    logic [7:0] enc_o;
    logic [1:0] chan_o;
    logic       out_ready = 1'b1;
    logic       done_o;
    logic       err_o;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [31:0] LV = 32'h0100_0000;

    always #5 clk = ~clk;

    rans_enc_multi dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .freq_wr_i  (freq_wr),
        .freq_i     (freq),
        .cum_freq_i (cum),
        .symb_i     (symb),
        .en_i       (en),
        .ready_o    (ready_o),
        .flush_i    (flush),
        .valid_o    (valid_o),
        .enc_o      (enc_o),
        .chan_o     (chan_o),
        .out_ready_i(out_ready),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr_tbl(input logic [7:0] s, input logic [9:0] f,
                          input logic [9:0] c);
        @(negedge clk);
        freq_wr = 1'b1;
        symb = s;
        freq = f;
        cum = c;
        @(negedge clk);
        freq_wr = 1'b0;
    endtask

    task automatic encode(input string tag, input logic [7:0] s,
                          input int stall, input int exp_lat,
                          input int exp_nw, input logic [7:0] exp_w,
                          input logic [1:0] exp_c);
        int n;
        int stalls;
        int nw;
        logic [7:0] e0;
        logic [1:0] c0;
        logic [7:0] w0;
        logic [1:0] wc0;
        n = 0;
        stalls = 0;
        nw = 0;
        e0 = '0;
        c0 = '0;
        w0 = '0;
        wc0 = '0;
        out_ready = (stall == 0);
        @(negedge clk);
        symb = s;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check({tag, "_rdy_drop"}, 32'(ready_o), 32'd0);
        while (!ready_o && n < 200) begin
            if (valid_o || (stalls > 0 && stalls < stall)) begin
                if (stalls < stall) begin
                    if (stalls == 0) begin
                        e0 = enc_o;
                        c0 = chan_o;
                    end else begin
                        check({tag, "_stall_v"}, 32'(valid_o), 32'd1);
                        check({tag, "_stall_e"}, 32'(enc_o), 32'(e0));
                        check({tag, "_stall_c"}, 32'(chan_o), 32'(c0));
                    end
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                    if (nw == 0) begin
                        w0 = enc_o;
                        wc0 = chan_o;
                    end
                    nw++;
                end
            end
            @(negedge clk);
            n++;
        end
        out_ready = 1'b1;
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_nwords"}, 32'(nw), 32'(exp_nw));
        if (exp_nw > 0) begin
            check({tag, "_word"}, 32'(w0), 32'(exp_w));
            check({tag, "_wchan"}, 32'(wc0), 32'(exp_c));
        end
    endtask

    task automatic do_flush(input string tag, input logic [31:0] exp0,
                            input logic [31:0] exp1);
        logic [31:0] got [2];
        int n;
        int cnt;
        got[0] = '0;
        got[1] = '0;
        n = 0;
        cnt = 0;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        while (cnt < 8 && n < 100) begin
            if (valid_o) begin
                got[cnt/4] = got[cnt/4] | (32'(enc_o) << (8 * (cnt % 4)));
                check({tag, "_chan"}, 32'(chan_o), 32'(cnt / 4));
                cnt++;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_count"}, 32'(cnt), 32'd8);
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_valid_end"}, 32'(valid_o), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        check({tag, "_ch0"}, got[0], exp0);
        check({tag, "_ch1"}, got[1], exp1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"}, 32'(ready_o), 32'd0);
        check({tag, "_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_enc"}, 32'(enc_o), 32'd0);
        check({tag, "_chan"}, 32'(chan_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_outs("por");
        rst = 1'b0;
        #1;
        check({"por_rdy_low"}, 32'(ready_o), 32'd0);
        @(negedge clk);
        check("por_rdy_rise", 32'(ready_o), 32'd1);

        wr_tbl(8'h41, 10'd512, 10'd0);
        wr_tbl(8'h42, 10'd1, 10'd5);

        // Test 1: reset in the middle of the divide
        @(negedge clk);
        symb = 8'h41;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outs("t1_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t1_rdy_low", 32'(ready_o), 32'd0);
        @(negedge clk);
        check("t1_rdy_rise", 32'(ready_o), 32'd1);
        do_flush("t1_fl", LV, LV);

        // Test 2: 0x41 needs no renorm
        encode("t2", 8'h41, 0, 35, 0, 8'h00, 2'd0);
        do_flush("t2_fl", 32'h0200_0000, LV);

        // Test 3: 0x42 renormalises one byte
        encode("t3", 8'h42, 0, 36, 1, 8'h00, 2'd0);
        do_flush("t3_fl", 32'h0400_0005, LV);

        // Test 4: round-robin over both channels
        encode("t4a", 8'h41, 0, 35, 0, 8'h00, 2'd0);
        encode("t4b", 8'h41, 0, 35, 0, 8'h00, 2'd0);
        do_flush("t4_fl", 32'h0200_0000, 32'h0200_0000);

        // Test 5: backpressure during renorm
        encode("t5", 8'h42, 10, 46, 1, 8'h00, 2'd0);
        do_flush("t5_fl", 32'h0400_0005, LV);

        // Test 6: zero-frequency symbol and write/enable collision
        wr_tbl(8'h43, 10'd0, 10'd0);
        encode("t6_zero", 8'h43, 0, 1, 0, 8'h00, 2'd0);
        check("t6_err", 32'(err_o), 32'd1);
        encode("t6_after", 8'h41, 0, 35, 0, 8'h00, 2'd0);
        @(negedge clk);
        freq_wr = 1'b1;
        en = 1'b1;
        symb = 8'h44;
        freq = 10'd256;
        cum = 10'd3;
        @(negedge clk);
        freq_wr = 1'b0;
        en = 1'b0;
        check("t6_wr_noacc", 32'(ready_o), 32'd1);
        @(negedge clk);
        check("t6_wr_idle", 32'(ready_o), 32'd1);
        encode("t6_new", 8'h44, 0, 35, 0, 8'h00, 2'd0);
        check("t6_err_sticky", 32'(err_o), 32'd1);
        do_flush("t6_fl", 32'h0200_0000, 32'h0400_0003);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_err_clr", 32'(err_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
